// File: rtl/ipu_int_ctrl.sv
// -----------------------------------------------------------------------------
// ipu_int_ctrl -- interrupt priority unit
//
// Sits at the requesting end of the fetch-stage interrupt interface. It
// latches rising edges on the peripheral request lines into a pending vector
// and arbitrates among unmasked pending sources by fixed priority, where the
// lowest index wins. It then presents one interrupt at a time to fetch. A new
// request is only issued after the current handler has returned (RTI seen as
// int_done).
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          synchronous active-high reset
//   irq_in       [NUM_SRC] peripheral request lines (rising edge = request)
//   irq_mask     [NUM_SRC] 1 = source blocked from dispatch (still latches)
//   int_ack      acknowledge from fetch
//   int_done     high for the cycle an RTI is in fetch
//   err_clr      clears the sticky timeout flag
//   ipu_int      registered interrupt request to fetch
//   int_id       [ID_W] index of the source being serviced
//   busy         controller is not idle
//   pending      [NUM_SRC] pending request vector
//   timeout_err  sticky flag: a request was abandoned for lack of int_ack
// -----------------------------------------------------------------------------
module ipu_int_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               err_clr,
    output logic               ipu_int,
    output logic [ID_W-1:0]    int_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [NUM_SRC-1:0] irq_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pending_next_s;
    logic [ID_W-1:0]    int_id_r;
    logic [ID_W-1:0]    int_id_next_s;
    logic               ipu_int_r;
    logic               ipu_int_next_s;
    logic               busy_r;
    logic               busy_next_s;
    logic               timeout_err_r;
    logic               timeout_err_next_s;
    logic [7:0]         cnt_r;
    logic [7:0]         cnt_next_s;
    logic [7:0]         cnt_inc_s;

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [ID_W-1:0]    winner_s;
    logic               found_s;
    logic               clr_en_s;
    logic               to_set_s;

    // Edge detection, arbitration and the pending-clear one-hot.
    always_comb begin
        edge_s     = irq_in & ~irq_prev_r;
        eligible_s = pending_r & ~irq_mask;
        found_s    = |eligible_s;
        winner_s   = {ID_W{1'b0}};
        // Scan from the top down so the lowest eligible index is left in winner_s.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            winner_s = eligible_s[i] ? ID_W'(i) : winner_s;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_s[i] = clr_en_s & (int_id_r == ID_W'(i));
        end
    end

    // Next-state and next-output logic of the dispatch FSM.
    always_comb begin
        state_next_s   = state_r;
        int_id_next_s  = int_id_r;
        ipu_int_next_s = 1'b0;
        cnt_next_s     = cnt_r;
        cnt_inc_s      = cnt_r + 8'd1;
        clr_en_s       = 1'b0;
        to_set_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    int_id_next_s  = winner_s;
                    ipu_int_next_s = 1'b1;
                    cnt_next_s     = 8'd0;
                    state_next_s   = ST_REQ;
                end else begin
                    int_id_next_s  = {ID_W{1'b0}};
                    ipu_int_next_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    clr_en_s       = 1'b1;
                    ipu_int_next_s = 1'b0;
                    state_next_s   = ST_SERVICE;
                end else if (cnt_inc_s == 8'(ACK_TIMEOUT)) begin
                    // Abandon the request; the pending bit stays so IDLE retries it.
                    cnt_next_s     = cnt_inc_s;
                    ipu_int_next_s = 1'b0;
                    to_set_s       = 1'b1;
                    state_next_s   = ST_IDLE;
                end else begin
                    cnt_next_s     = cnt_inc_s;
                    ipu_int_next_s = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    int_id_next_s = {ID_W{1'b0}};
                    state_next_s  = ST_IDLE;
                end else begin
                    int_id_next_s = int_id_r;
                end
            end
            default: begin
                int_id_next_s = {ID_W{1'b0}};
                state_next_s  = ST_IDLE;
            end
        endcase

        // A new edge on the bit being acknowledged must survive the clear.
        pending_next_s = (pending_r & ~clr_s) | edge_s;

        // A new timeout takes precedence over a simultaneous err_clr.
        if (to_set_s) begin
            timeout_err_next_s = 1'b1;
        end else if (err_clr) begin
            timeout_err_next_s = 1'b0;
        end else begin
            timeout_err_next_s = timeout_err_r;
        end

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        irq_prev_r <= irq_in;
        if (rst) begin
            state_r       <= ST_IDLE;
            pending_r     <= {NUM_SRC{1'b0}};
            int_id_r      <= {ID_W{1'b0}};
            ipu_int_r     <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            cnt_r         <= 8'd0;
        end else begin
            state_r       <= state_next_s;
            pending_r     <= pending_next_s;
            int_id_r      <= int_id_next_s;
            ipu_int_r     <= ipu_int_next_s;
            busy_r        <= busy_next_s;
            timeout_err_r <= timeout_err_next_s;
            cnt_r         <= cnt_next_s;
        end
    end

    assign ipu_int     = ipu_int_r;
    assign int_id      = int_id_r;
    assign busy        = busy_r;
    assign pending     = pending_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ipu_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ipu_int_ctrl -- directed testbench for ipu_int_ctrl.
// The status word is {ipu_int, int_id[1:0], busy, pending[3:0], timeout_err}.
// It is sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_ipu_int_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] irq_mask;
    logic       int_ack;
    logic       int_done;
    logic       err_clr;
    logic       ipu_int;
    logic [1:0] int_id;
    logic       busy;
    logic [3:0] pending;
    logic       timeout_err;
    logic [8:0] status;

    int n_checks = 0;
    int n_fail   = 0;

    ipu_int_ctrl #(.NUM_SRC(4), .ID_W(2), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
        .int_ack(int_ack), .int_done(int_done), .err_clr(err_clr),
        .ipu_int(ipu_int), .int_id(int_id), .busy(busy),
        .pending(pending), .timeout_err(timeout_err)
    );

    assign status = {ipu_int, int_id, busy, pending, timeout_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = 4'b0001; irq_mask = 4'b0000;
        int_ack = 1'b0; int_done = 1'b0; err_clr = 1'b0;
        step(); step();
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL reset_state: got %b exp %b", status, 9'b0_00_0_0000_0); end
        rst = 1'b0;
        step();
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL reset_held_line: got %b exp %b", status, 9'b0_00_0_0000_0); end
        step();
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL reset_no_dispatch: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000;
        step();
    endtask

    task automatic test_single();
        irq_in = 4'b0100; step();
        n_checks++; if (status !== 9'b0_00_0_0100_0) begin n_fail++; $display("FAIL single_pend: got %b exp %b", status, 9'b0_00_0_0100_0); end
        step();
        n_checks++; if (status !== 9'b1_10_1_0100_0) begin n_fail++; $display("FAIL single_dispatch: got %b exp %b", status, 9'b1_10_1_0100_0); end
        step();
        n_checks++; if (status !== 9'b1_10_1_0100_0) begin n_fail++; $display("FAIL single_wait: got %b exp %b", status, 9'b1_10_1_0100_0); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_10_1_0000_0) begin n_fail++; $display("FAIL single_ack: got %b exp %b", status, 9'b0_10_1_0000_0); end
        step();
        n_checks++; if (status !== 9'b0_10_1_0000_0) begin n_fail++; $display("FAIL single_service: got %b exp %b", status, 9'b0_10_1_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL single_done: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000; step();
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL single_idle: got %b exp %b", status, 9'b0_00_0_0000_0); end
    endtask

    task automatic test_priority();
        irq_mask = 4'b0010; irq_in = 4'b1010; step();
        n_checks++; if (status !== 9'b0_00_0_1010_0) begin n_fail++; $display("FAIL prio_pend: got %b exp %b", status, 9'b0_00_0_1010_0); end
        step();
        n_checks++; if (status !== 9'b1_11_1_1010_0) begin n_fail++; $display("FAIL prio_src3_first: got %b exp %b", status, 9'b1_11_1_1010_0); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_11_1_0010_0) begin n_fail++; $display("FAIL prio_ack3: got %b exp %b", status, 9'b0_11_1_0010_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0010_0) begin n_fail++; $display("FAIL prio_done3: got %b exp %b", status, 9'b0_00_0_0010_0); end
        step();
        n_checks++; if (status !== 9'b0_00_0_0010_0) begin n_fail++; $display("FAIL prio_masked_hold: got %b exp %b", status, 9'b0_00_0_0010_0); end
        irq_mask = 4'b0000; step();
        n_checks++; if (status !== 9'b1_01_1_0010_0) begin n_fail++; $display("FAIL prio_src1_next: got %b exp %b", status, 9'b1_01_1_0010_0); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_01_1_0000_0) begin n_fail++; $display("FAIL prio_ack1: got %b exp %b", status, 9'b0_01_1_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL prio_done1: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000; step();
    endtask

    task automatic test_timeout();
        int hi;
        irq_in = 4'b0001; step();
        n_checks++; if (status !== 9'b0_00_0_0001_0) begin n_fail++; $display("FAIL to_pend: got %b exp %b", status, 9'b0_00_0_0001_0); end
        step();
        n_checks++; if (status !== 9'b1_00_1_0001_0) begin n_fail++; $display("FAIL to_dispatch: got %b exp %b", status, 9'b1_00_1_0001_0); end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ipu_int === 1'b1) hi++;
            else break;
        end
        n_checks++; if (hi != 15) begin n_fail++; $display("FAIL to_width: got %0d cycles exp %0d", hi, 15); end
        n_checks++; if (status !== 9'b0_00_0_0001_1) begin n_fail++; $display("FAIL to_drop: got %b exp %b", status, 9'b0_00_0_0001_1); end
        step();
        n_checks++; if (status !== 9'b1_00_1_0001_1) begin n_fail++; $display("FAIL to_retry: got %b exp %b", status, 9'b1_00_1_0001_1); end
        err_clr = 1'b1; int_ack = 1'b1; step(); err_clr = 1'b0; int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_00_1_0000_0) begin n_fail++; $display("FAIL to_err_clr: got %b exp %b", status, 9'b0_00_1_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL to_done: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000; step();
    endtask

    task automatic test_collision();
        irq_in = 4'b0100; step(); step();
        n_checks++; if (status !== 9'b1_10_1_0100_0) begin n_fail++; $display("FAIL col_dispatch: got %b exp %b", status, 9'b1_10_1_0100_0); end
        irq_in = 4'b0000; step();
        n_checks++; if (status !== 9'b1_10_1_0100_0) begin n_fail++; $display("FAIL col_req_hold: got %b exp %b", status, 9'b1_10_1_0100_0); end
        irq_in = 4'b0100; int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_10_1_0100_0) begin n_fail++; $display("FAIL col_set_wins: got %b exp %b", status, 9'b0_10_1_0100_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0100_0) begin n_fail++; $display("FAIL col_done: got %b exp %b", status, 9'b0_00_0_0100_0); end
        step();
        n_checks++; if (status !== 9'b1_10_1_0100_0) begin n_fail++; $display("FAIL col_redispatch: got %b exp %b", status, 9'b1_10_1_0100_0); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_10_1_0000_0) begin n_fail++; $display("FAIL col_ack2: got %b exp %b", status, 9'b0_10_1_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        irq_in = 4'b0000; step();
    endtask

    task automatic test_ordering();
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL ord_done_idle: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0010; step(); step();
        n_checks++; if (status !== 9'b1_01_1_0010_0) begin n_fail++; $display("FAIL ord_dispatch: got %b exp %b", status, 9'b1_01_1_0010_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b1_01_1_0010_0) begin n_fail++; $display("FAIL ord_done_req: got %b exp %b", status, 9'b1_01_1_0010_0); end
        int_ack = 1'b1; step();
        n_checks++; if (status !== 9'b0_01_1_0000_0) begin n_fail++; $display("FAIL ord_ack: got %b exp %b", status, 9'b0_01_1_0000_0); end
        step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_01_1_0000_0) begin n_fail++; $display("FAIL ord_ack_service: got %b exp %b", status, 9'b0_01_1_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL ord_done: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000; step();
    endtask

    task automatic test_reset_service();
        irq_in = 4'b1000; step(); step();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        n_checks++; if (status !== 9'b0_11_1_0000_0) begin n_fail++; $display("FAIL rst_in_service: got %b exp %b", status, 9'b0_11_1_0000_0); end
        irq_in = 4'b1010; step();
        n_checks++; if (status !== 9'b0_11_1_0010_0) begin n_fail++; $display("FAIL rst_pend_in_service: got %b exp %b", status, 9'b0_11_1_0010_0); end
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL rst_mid_service: got %b exp %b", status, 9'b0_00_0_0000_0); end
        int_done = 1'b1; step(); int_done = 1'b0;
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL rst_stray_done: got %b exp %b", status, 9'b0_00_0_0000_0); end
        step();
        n_checks++; if (status !== 9'b0_00_0_0000_0) begin n_fail++; $display("FAIL rst_quiet: got %b exp %b", status, 9'b0_00_0_0000_0); end
        irq_in = 4'b0000; step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_collision();
        test_ordering();
        test_reset_service();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ipu_int_ctrl.md
Name: ipu_int_ctrl

Overview:
Interrupt priority unit. It is the requesting end of the fetch-stage interrupt interface: it drives ipu_int into fetch and consumes int_ack and int_done (RTI decode, opcode 4'b0011) coming back. It collects edge-triggered requests from NUM_SRC peripheral lines, arbitrates by fixed priority and presents one interrupt at a time. No new request is issued until the current handler has returned.

Parameters:
NUM_SRC, 4, number of interrupt source lines (2..16)
ID_W, 2, width of int_id; must be >= clog2(NUM_SRC)
ACK_TIMEOUT, 15, cycles to wait in REQ for int_ack before abandoning the request (1..255)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous active-high reset
irq_in  input  NUM_SRC  peripheral request lines; a rising edge requests service
irq_mask  input  NUM_SRC  1 = source blocked from dispatch (its pending bit still latches)
int_ack  input  1  acknowledge from fetch (fetch's registered int_output)
int_done  input  1  high for the cycle an RTI is in fetch
err_clr  input  1  clears timeout_err
ipu_int  output  1  interrupt request to fetch (registered)
int_id  output  ID_W  index of the source being serviced
busy  output  1  state != IDLE
pending  output  NUM_SRC  pending request vector
timeout_err  output  1  sticky flag: a request timed out

Behaviour:
- Reset (rst sampled high at posedge):
  - state = IDLE; ipu_int, int_id, pending, timeout_err and the timeout counter all go to 0.
  - irq_prev <= irq_in, so a line already high at reset release does not count as an edge.
- Edge detect, every cycle: edge[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in.
- pending update:
  - pending[i] is set on edge[i].
  - pending[i] is cleared when source i is acknowledged (REQ with int_ack=1).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Repeated edges while already pending merge into one request.
- Arbitration: eligible = pending & ~irq_mask. The lowest index wins. Arbitration is evaluated only in IDLE.
- FSM:
  - IDLE:
    - If eligible != 0: latch int_id = winner, ipu_int <= 1, counter <= 0, go to REQ.
    - Otherwise ipu_int = 0 and int_id = 0.
  - REQ:
    - ipu_int is held at 1; int_id is frozen; masking changes are ignored.
    - int_ack=1: clear pending[int_id], ipu_int <= 0, go to SERVICE.
    - int_ack=0: counter++. When counter reaches ACK_TIMEOUT, set ipu_int <= 0 and timeout_err <= 1, go to IDLE. pending is kept, so the request is retried.
    - int_done in REQ is ignored.
  - SERVICE:
    - ipu_int = 0; int_id is held.
    - int_done=1: go to IDLE. int_id clears to 0 on the same edge.
    - int_ack in SERVICE is ignored.
- Latency: irq_in is first sampled high at posedge k. pending is set after posedge k and ipu_int is high after posedge k+1. A new dispatch after int_done occurs no earlier than one cycle after returning to IDLE.
- timeout_err is sticky. It clears on rst or on err_clr. If a set and err_clr occur in the same cycle, the set wins.
- All outputs are driven from registers; ipu_int has no combinational path from any input.

Test Plan:
1. Single request: after reset, pulse irq_in[2] 0->1, hold int_ack=0 one cycle, then 1 -> ipu_int rises 2 cycles after the edge, int_id=2; pending=4'b0100 then 0 on the ack edge; busy stays 1 until an int_done pulse, then IDLE with int_id=0.
2. Priority and masking: raise irq_in[3] and irq_in[1] in the same cycle with irq_mask=4'b0010 -> source 3 is serviced first. After its int_done, clear the mask -> source 1 is dispatched next. pending goes 1010 -> 0010 -> 0000.
3. Timeout: raise irq_in[0] and never ack -> ipu_int stays high exactly ACK_TIMEOUT(15) cycles, then drops; timeout_err=1, pending[0] is still 1, and ipu_int re-asserts on the following cycle. err_clr pulse -> timeout_err=0.
4. Collision: in REQ for source 2, apply a new edge on irq_in[2] in the same cycle as int_ack=1 -> pending[2] remains 1, and source 2 is re-dispatched after int_done.
5. Reset: hold irq_in=4'b0001 through reset -> no request after reset release (pending=0). Assert rst mid-SERVICE -> next cycle all outputs are 0, state is IDLE, and a stray int_done has no effect.
6. Ordering: pulse int_done while IDLE and while in REQ -> no state change; pulse int_ack while in SERVICE -> ignored.
